load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 75 +++++++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_load_extend.sv | 36 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: memory op encoding,
// FSM states, byte-enable masks and store-lane replication.
package LSU_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LH  = 4'b0001,
    OP_LW  = 4'b0010,
    OP_LBU = 4'b0100,
    OP_LHU = 4'b0101,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_is_aligned(input logic [3:0] op, input logic [1:0] lo);
    case (op_size(op))
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] be_mask(input logic [3:0] op, input logic [1:0] lo);
    case (op_size(op))
      SZ_BYTE: return BE_BYTE << lo;
      SZ_HALF: return lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  // Replicate the store operand into every lane so the memory picks it up via BE alone
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
    case (op_size(op))
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit (master)
// and the memory (slave).
interface load_store_unit_if;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational lane select and sign/zero extension of a returned memory word.
module load_extend
  import LSU_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h000000, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks and latches an execute-stage
// memory op, drives one dmem request, and returns extended load data.
module load_store_unit
  import LSU_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        lsu_ready_o,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        done_o,
  output logic        misaligned_o,
  output logic        err_o,
  load_store_unit_if.master dmem
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  r_state;
  lsu_state_e  w_nextState;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_rdataValid;
  logic        r_done;
  logic        r_misaligned;
  logic        r_err;

  logic        w_legal;
  logic        w_aligned;
  logic        w_accept;
  logic        w_store;
  logic        w_inReq;
  logic        w_timeout;
  logic [31:0] w_loadData;

  assign w_legal   = op_is_legal(mem_op_i);
  assign w_aligned = op_is_aligned(mem_op_i, addr_i[1:0]);
  assign w_accept  = (r_state == IDLE) && lsu_valid_i && w_legal && w_aligned;
  assign w_store   = op_is_store(r_op);
  assign w_timeout = (r_cnt == CNT_LAST);

  load_extend u_load_extend (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (dmem.dmem_rdata_i),
    .o_data    (w_loadData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = REQ;
      REQ:     if (dmem.dmem_gnt_i) w_nextState = w_store ? IDLE : WAIT_R;
      WAIT_R:  if (dmem.dmem_rvalid_i || w_timeout) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Bus outputs are zeroed outside REQ so nothing stale reaches memory
  always_comb begin
    lsu_ready_o       = (r_state == IDLE);
    stall_o           = w_accept || (r_state != IDLE);
    w_inReq           = (r_state == REQ);
    dmem.dmem_req_o   = w_inReq;
    dmem.dmem_we_o    = w_inReq && w_store;
    dmem.dmem_addr_o  = w_inReq ? {r_addr[31:2], 2'b00} : 32'h0;
    dmem.dmem_be_o    = w_inReq ? r_be : 4'b0000;
    dmem.dmem_wdata_o = w_inReq ? r_wdata : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= 4'b0000;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_be         <= 4'b0000;
      r_cnt        <= 8'd0;
      r_rdata      <= 32'h0;
      r_rdataValid <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rdataValid <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (lsu_valid_i) begin
            if (!w_legal) begin
              r_err <= 1'b1;
            end else if (!w_aligned) begin
              r_misaligned <= 1'b1;
            end else begin
              r_op    <= mem_op_i;
              r_addr  <= addr_i;
              r_wdata <= store_data(mem_op_i, wdata_i);
              r_be    <= be_mask(mem_op_i, addr_i[1:0]);
            end
          end
        end
        REQ: begin
          if (dmem.dmem_gnt_i) begin
            r_cnt <= 8'd0;
            if (w_store) r_done <= 1'b1;
          end
        end
        WAIT_R: begin
          if (dmem.dmem_rvalid_i) begin
            r_rdata      <= w_loadData;
            r_rdataValid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rdataValid;
  assign done_o        = r_done;
  assign misaligned_o  = r_misaligned;
  assign err_o         = r_err;

endmodule
